// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters, with a one-entry tagged response register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam logic [3:0] c_FIRST_UNDEF_OP = 4'd10;

  logic             r_last;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;

  logic [1:0]       w_grant;
  logic             w_gid;
  logic             w_free;
  logic             w_xfer;
  logic             w_undef;
  logic [TAG_W-1:0] w_tag;

  // Grant selection: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_gid  = w_grant[1];
  assign w_free = ~r_rsp_valid | rsp_ready;
  // Ready is forced low while reset is asserted so nothing can transfer.
  assign req_ready = (rst_n && w_free) ? w_grant : 2'b00;
  assign w_xfer    = |(req_valid & req_ready);

  // Steer the granted operation onto the shared ALU; idle inputs are zeroed.
  always_comb begin
    alu_op   = 4'd0;
    alu_src1 = 32'd0;
    alu_src2 = 32'd0;
    w_tag    = '0;
    if (w_grant == 2'b01) begin
      alu_op   = req0_op;
      alu_src1 = req0_src1;
      alu_src2 = req0_src2;
      w_tag    = req0_tag;
    end else if (w_grant == 2'b10) begin
      alu_op   = req1_op;
      alu_src1 = req1_src1;
      alu_src2 = req1_src2;
      w_tag    = req1_tag;
    end
  end

  assign w_undef = (alu_op >= c_FIRST_UNDEF_OP);

  // Round-robin pointer and response register; pointer moves only on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_id    <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_xfer) begin
      r_last      <= w_gid;
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_undef ? 32'd0 : alu_d;
      r_rsp_id    <= w_gid;
      r_rsp_tag   <= w_tag;
      r_rsp_err   <= w_undef;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Self-checking bench for alu_share_arb with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [3:0]       req0_op = '0, req1_op = '0;
  logic [31:0]      req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [3:0]       alu_op;
  logic [31:0]      alu_src1, alu_src2, alu_d;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic             m_valid, m_id, m_err, m_last;
  logic [31:0]      m_data;
  logic [TAG_W-1:0] m_tag;
  int               xfer_id;

  alu_share_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_d(alu_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU; undefined opcodes return junk so the zeroing is observable.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a ^ b;
      4'd3: return a | b;
      4'd4: return a & b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_d = alu_ref(alu_op, alu_src1, alu_src2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_tag = '0; m_err = 1'b0; m_last = 1'b1;
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    int g;
    logic [1:0] er;
    logic [3:0] eop;
    logic [31:0] e1, e2;
    logic [TAG_W-1:0] etg;
    @(negedge clk);
    g = -1;
    if (req_valid == 2'b01) g = 0;
    else if (req_valid == 2'b10) g = 1;
    else if (req_valid == 2'b11) g = m_last ? 0 : 1;
    eop = (g == 0) ? req0_op : (g == 1) ? req1_op : 4'd0;
    e1  = (g == 0) ? req0_src1 : (g == 1) ? req1_src1 : 32'd0;
    e2  = (g == 0) ? req0_src2 : (g == 1) ? req1_src2 : 32'd0;
    etg = (g == 0) ? req0_tag : (g == 1) ? req1_tag : '0;
    if (!rst_n) begin
      model_reset();
      er = 2'b00;
    end else begin
      er = (g >= 0 && (!m_valid || rsp_ready)) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("alu_op", {28'd0, alu_op}, {28'd0, eop});
      chk("alu_src1", alu_src1, e1);
      chk("alu_src2", alu_src2, e2);
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    chk("rsp_tag", {{(32-TAG_W){1'b0}}, rsp_tag}, {{(32-TAG_W){1'b0}}, m_tag});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    xfer_id = (er != 2'b00) ? g : -1;
    @(posedge clk);
    if (rst_n) begin
      if (xfer_id >= 0) begin
        m_valid = 1'b1;
        m_err   = (eop >= 4'd10);
        m_data  = m_err ? 32'd0 : alu_ref(eop, e1, e2);
        m_id    = xfer_id[0];
        m_tag   = etg;
        m_last  = xfer_id[0];
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] lit;
    logic p0, p1;
    model_reset();
    xfer_id = -1;

    // Reset, then a single add from requester 0
    rst_n = 1'b0; rsp_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    req0_op = 4'd0; req0_src1 = 32'd5; req0_src2 = 32'd7; req0_tag = 4'd3;
    req_valid = 2'b01;
    #1 chk("single_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_data", rsp_data, 32'd12);
    chk("single_id", {31'd0, rsp_id}, 32'd0);
    chk("single_tag", {28'd0, rsp_tag}, 32'd3);
    chk("single_err", {31'd0, rsp_err}, 32'd0);

    // Requester 1 alone, then contention with strict alternation
    req1_op = 4'd7; req1_src1 = 32'h8000_0000; req1_src2 = 32'd4; req1_tag = 4'd9;
    req_valid = 2'b10;
    step();
    chk("r1_alone_id", {31'd0, rsp_id}, 32'd1);
    req0_op = 4'd1; req0_src1 = 32'd1; req0_src2 = 32'd2; req0_tag = 4'd6;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_id", {31'd0, rsp_id}, k % 2);
      lit = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'hF800_0000;
      chk("alt_data", rsp_data, lit);
    end

    // Backpressure: held response, no acceptance, pointer frozen
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", {30'd0, req_ready}, 32'd0);
      step();
      chk("bp_data", rsp_data, 32'hF800_0000);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", {30'd0, req_ready}, 32'd1);
    step();
    chk("bp_release_id", {31'd0, rsp_id}, 32'd0);
    chk("bp_release_data", rsp_data, 32'hFFFF_FFFF);
    req_valid = 2'b00;
    step();

    // Undefined opcode, then sltu
    req1_op = 4'd12; req1_src1 = 32'd3; req1_src2 = 32'd4; req1_tag = 4'd5;
    req_valid = 2'b10;
    step();
    chk("undef_err", {31'd0, rsp_err}, 32'd1);
    chk("undef_data", rsp_data, 32'd0);
    chk("undef_id", {31'd0, rsp_id}, 32'd1);
    req1_op = 4'd9; req1_src1 = 32'd1; req1_src2 = 32'd2;
    step();
    chk("sltu_err", {31'd0, rsp_err}, 32'd0);
    chk("sltu_data", rsp_data, 32'd1);

    // Reset while a response is held
    req_valid = 2'b00; rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_async_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_async_data", rsp_data, 32'd0);
    model_reset();
    step(); step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1 chk("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    req_valid = 2'b00;
    step();

    // Randomized traffic; each requester holds its request until accepted
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (xfer_id == 0) p0 = 1'b0;
      if (xfer_id == 1) p1 = 1'b0;
      if (!p0 && ($urandom % 3 != 0)) begin
        p0 = 1'b1;
        req0_op = 4'($urandom_range(0, 15));
        req0_src1 = ($urandom % 2) ? $urandom : $urandom_range(0, 40);
        req0_src2 = ($urandom % 2) ? $urandom : $urandom_range(0, 40);
        req0_tag = 4'($urandom);
      end
      if (!p1 && ($urandom % 3 != 0)) begin
        p1 = 1'b1;
        req1_op = 4'($urandom_range(0, 15));
        req1_src1 = ($urandom % 2) ? $urandom : $urandom_range(0, 40);
        req1_src2 = ($urandom % 2) ? $urandom : $urandom_range(0, 40);
        req1_tag = 4'($urandom);
      end
      req_valid = {p1, p0};
      rsp_ready = ($urandom % 4 != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and response register that shares one combinational `alu_r` between two execute-stage requesters. Each requester presents an operation over a valid/ready handshake. The block steers the granted operation onto the ALU inputs, captures the result with a one-entry response register, and returns it tagged with the originating requester.

## Interface
Parameters:
- `TAG_W`, default 4: width of the requester-supplied tag carried through to the response.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  2: per-requester request valid; bit i is requester i.
- `req_ready`  out  2: per-requester accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req0_op`, `req1_op`  in  4 each: ALU opcode.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2`  in  32 each: operands.
- `req0_tag`, `req1_tag`  in  TAG_W each: opaque tag.
- `alu_op`  out  4: to `alu_r`; granted requester's opcode, 0 when nothing is granted.
- `alu_src1`, `alu_src2`  out  32 each: to `alu_r`; granted operands, 0 when nothing is granted.
- `alu_d`  in  32: combinational result from `alu_r`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accept.
- `rsp_data`  out  32: result.
- `rsp_id`  out  1: requester index that issued the operation.
- `rsp_tag`  out  TAG_W: tag of the issuing request.
- `rsp_err`  out  1: the opcode was undefined (10–15).

## Operation
- Opcode map: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu. Shifts use `src2[4:0]`. Results are 32-bit and wrap mod 2^32.
- Round-robin state is a 1-bit `last` pointer. Reset value is 1, so requester 0 wins the first contention.
- Grant selection:
  - Only one `req_valid` set: grant that requester.
  - Both set: grant `~last`.
  - Neither set: no grant; ALU inputs are driven to 0.
- `last` updates to the granted index only on an actual transfer, not on a stalled grant.
- Slot-free condition: `free = ~rsp_valid | rsp_ready`.
- `req_ready[i] = grant[i] & free`. At most one bit of `req_ready` is set in any cycle.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. `req_valid` must not depend on `req_ready`.
- On a transfer, the response register loads:
  - `rsp_data` ← `alu_d`, or 0 if op ≥ 10.
  - `rsp_id` ← the granted index.
  - `rsp_tag` ← the granted tag.
  - `rsp_err` ← (op ≥ 10).
  - `rsp_valid` ← 1.
- If `rsp_valid & rsp_ready` with no new transfer, `rsp_valid` goes to 0. Data fields hold their last value.
- If `rsp_valid & ~rsp_ready`, all response outputs hold stable and both `req_ready` bits are 0.
- Simultaneous drain and transfer: the new response replaces the old one in the same edge and `rsp_valid` stays 1.
- Requesters must hold `valid`, `op`, operands and tag stable until accepted. The arbiter must not reorder or drop a granted request.
- Reset mid-operation: any held response is discarded, and outputs return to their reset values asynchronously.

## Timing
- Reset values:
  - `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `rsp_tag` 0, `rsp_err` 0.
  - `last` 1.
  - `req_ready` 0 while `rst_n` is low.
- Latency: a request accepted at edge N is presented on `rsp_*` from after edge N, i.e. visible in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Fairness: with both requesters continuously valid and `rsp_ready` high, grants strictly alternate 0,1,0,1…
- No requester waits more than one accepted transfer of the other before being granted.

## Test plan
- **Reset, then single request.** Reset, then req0 only: add 5+7, tag 3. Required: `req_ready` = 01 in the same cycle; the next cycle shows `rsp_valid`=1, `rsp_data`=12, `rsp_id`=0, `rsp_tag`=3, `rsp_err`=0.
- **Contention alternation.** Both requesters valid for 4 cycles with `rsp_ready`=1; req0 issues sub 1−2, req1 issues sra 0x80000000 by 4. Required: grant order 0,1,0,1; responses 0xFFFFFFFF (id 0) and 0xF8000000 (id 1) alternate.
- **Backpressure.** `rsp_ready`=0 with a valid response held for 3 cycles while both requesters are valid. Required: `req_ready`=00 and `rsp_*` stable. When `rsp_ready` rises, the pending winner is accepted that cycle and `last` does not advance during the stall.
- **Undefined opcode.** req1 with op 12. Required: `rsp_err`=1, `rsp_data`=0, `rsp_id`=1. A following op 9 (sltu 1<2) returns `rsp_err`=0, `rsp_data`=1.
- **Reset during a held response.** Assert `rst_n` low while a response is held with `rsp_ready`=0. Required: `rsp_valid` drops immediately without waiting for a clock; after release, the first contention grants requester 0.
